// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the MMIO hub.
//   - word offsets of each register inside the MMIO window
//   - bit positions inside the timer control register
//   - default first word address of the MMIO window
package mmio_pkg;

  localparam int OFF_LED       = 0;
  localparam int OFF_BTN_LEVEL = 1;
  localparam int OFF_BTN_EDGE  = 2;
  localparam int OFF_TMR_COUNT = 3;
  localparam int OFF_TMR_CMP   = 4;
  localparam int OFF_TMR_CTRL  = 5;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_PEND  = 1;
  localparam int CTRL_CLEAR = 2;

  localparam logic [11:0] MMIO_BASE_DEFAULT = 12'hF00;

endpackage

// File: rtl/mmio_hub_if.sv
// mmio_hub_if: processor data-memory port as seen by the hub.
//   address_dmem : word address from the processor (32 bits)
//   wren         : write enable
//   data         : write data
//   q_dmem       : read data back to the processor, one cycle after the address
// Modports: master = processor side, slave = hub side.
interface mmio_hub_if;

  logic [31:0] address_dmem;
  logic        wren;
  logic [31:0] data;
  logic [31:0] q_dmem;

  modport master (output address_dmem, wren, data, input q_dmem);
  modport slave  (input address_dmem, wren, data, output q_dmem);

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: one button path.
//   clock, reset : system clock, asynchronous active-low reset
//   btn_i        : raw asynchronous button input
//   level_o      : debounced level
//   rise_o       : high in the cycle the debounced level is about to go 0->1,
//                  so the owner's edge flag sets on the same edge as the level
// The synchronised input must disagree with the accepted level for
// DEBOUNCE_CYCLES consecutive cycles before the level follows it.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             toggle;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    toggle  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      toggle  = 1'b1;
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = toggle & ~level_q;

endmodule

// File: rtl/mmio_hub.sv
// mmio_hub: splits processor data accesses between RAM and an MMIO window
// and owns the peripherals behind that window.
//   clock, reset  : system clock, asynchronous active-low reset
//   bus           : processor data port (mmio_hub_if.slave)
//   ram_addr      : RAM word address (low ADDR_W bits of the processor address)
//   ram_wEn       : RAM write enable, suppressed for MMIO accesses
//   ram_dataIn    : RAM write data
//   ram_dataOut   : RAM read data, one cycle after the address
//   btn_in        : raw button inputs
//   led_out       : LED register
//   irq           : timer compare interrupt (pending bit)
// MMIO reads are registered so both targets return data with the same
// one-cycle latency; q_dmem chooses between them with the registered select.
module mmio_hub import mmio_pkg::*; #(
  parameter int                ADDR_W          = 12,
  parameter logic [ADDR_W-1:0] MMIO_BASE       = ADDR_W'(MMIO_BASE_DEFAULT),
  parameter int                N_LED           = 8,
  parameter int                N_BTN           = 4,
  parameter int                DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  mmio_hub_if.slave         bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wEn,
  output logic [31:0]       ram_dataIn,
  input  logic [31:0]       ram_dataOut,
  input  logic [N_BTN-1:0]  btn_in,
  output logic [N_LED-1:0]  led_out,
  output logic              irq
);

  logic [ADDR_W-1:0] addr, off;
  logic              mmio_sel, wrAcc, rdEdge;
  logic              unusedAddrBits;

  logic [N_LED-1:0]  led_q, led_d;
  logic [N_BTN-1:0]  edge_q, edge_d, edgeClr;
  logic [N_BTN-1:0]  level, rise;
  logic [31:0]       count_q, count_d, cmp_q, cmp_d;
  logic              en_q, en_d, pend_q, pend_d;
  logic              ctrlWr, match;
  logic              sel_q;
  logic [31:0]       mmio_rd_q, rdVal;

  assign addr           = bus.address_dmem[ADDR_W-1:0];
  assign unusedAddrBits = ^bus.address_dmem[31:ADDR_W];
  assign mmio_sel       = (addr >= MMIO_BASE);
  assign off            = addr - MMIO_BASE;
  assign wrAcc          = mmio_sel & bus.wren;
  assign rdEdge         = mmio_sel & ~bus.wren & (off == ADDR_W'(OFF_BTN_EDGE));
  assign ctrlWr         = wrAcc & (off == ADDR_W'(OFF_TMR_CTRL));
  assign match          = en_q & (count_q == cmp_q);

  assign ram_addr   = addr;
  assign ram_wEn    = bus.wren & ~mmio_sel;
  assign ram_dataIn = bus.data;

  for (genvar i = 0; i < N_BTN; i++) begin : gBtn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebounce (
      .clock  (clock),
      .reset  (reset),
      .btn_i  (btn_in[i]),
      .level_o(level[i]),
      .rise_o (rise[i])
    );
  end

  always_comb begin
    rdVal = '0;
    case (off)
      ADDR_W'(OFF_LED):       rdVal = 32'(led_q);
      ADDR_W'(OFF_BTN_LEVEL): rdVal = 32'(level);
      ADDR_W'(OFF_BTN_EDGE):  rdVal = 32'(edge_q);
      ADDR_W'(OFF_TMR_COUNT): rdVal = count_q;
      ADDR_W'(OFF_TMR_CMP):   rdVal = cmp_q;
      ADDR_W'(OFF_TMR_CTRL):  rdVal = 32'({pend_q, en_q});
      default:                rdVal = '0;
    endcase
  end

  // Edge flags: a read of the edge register clears exactly the bits it
  // returned, a write clears the bits written as 1; a new rising edge on the
  // same cycle always survives because it is OR-ed in after the clear.
  always_comb begin
    edgeClr = '0;
    if (rdEdge) begin
      edgeClr = edge_q;
    end else if (wrAcc && off == ADDR_W'(OFF_BTN_EDGE)) begin
      edgeClr = bus.data[N_BTN-1:0];
    end
    edge_d = (edge_q & ~edgeClr) | rise;
  end

  // Register writes and timer. The count clear takes priority over the
  // increment, and a compare match beats a pending W1C in the same cycle.
  always_comb begin
    led_d   = led_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    pend_d  = pend_q;
    count_d = count_q;
    if (wrAcc && off == ADDR_W'(OFF_LED)) led_d = bus.data[N_LED-1:0];
    if (wrAcc && off == ADDR_W'(OFF_TMR_CMP)) cmp_d = bus.data;
    if (ctrlWr) en_d = bus.data[CTRL_EN];
    if (ctrlWr && bus.data[CTRL_PEND]) pend_d = 1'b0;
    if (match) pend_d = 1'b1;
    if (ctrlWr && bus.data[CTRL_CLEAR]) begin
      count_d = '0;
    end else if (en_q) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q     <= '0;
      edge_q    <= '0;
      count_q   <= '0;
      cmp_q     <= '0;
      en_q      <= 1'b0;
      pend_q    <= 1'b0;
      sel_q     <= 1'b0;
      mmio_rd_q <= '0;
    end else begin
      led_q     <= led_d;
      edge_q    <= edge_d;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      sel_q     <= mmio_sel;
      mmio_rd_q <= rdVal;
    end
  end

  assign bus.q_dmem = sel_q ? mmio_rd_q : ram_dataOut;
  assign led_out    = led_q;
  assign irq        = pend_q;

endmodule

// File: doc/mmio_hub.md
Name: mmio_hub

Overview:
- Sits between the processor data-memory port and RAM in the top-level wrapper.
- Decodes each data access to either RAM or a memory-mapped peripheral window.
- Owns the peripherals: a parametrised LED register, N debounced buttons with sticky edge flags, and a 32-bit timer with compare interrupt.
- Generalises the wrapper's hard-wired LED=pc hookup into software-controlled I/O.

Parameters:
- ADDR_W, 12, word-address width forwarded to RAM.
- MMIO_BASE, 12'hF00, first word address of the MMIO window; addresses >= MMIO_BASE are MMIO.
- N_LED, 8, LED register width (1..32).
- N_BTN, 4, number of button inputs (1..32).
- DEBOUNCE_CYCLES, 1000000, stable cycles required before a button level change is accepted (>=1).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- address_dmem  in  32  processor data address; bits [ADDR_W-1:0] are decoded, upper bits ignored.
- wren  in  1  processor write enable.
- data  in  32  processor write data.
- q_dmem  out  32  read data to processor.
- ram_addr  out  ADDR_W  RAM address, equal to address_dmem[ADDR_W-1:0].
- ram_wEn  out  1  RAM write enable, equal to wren & ~mmio_sel.
- ram_dataIn  out  32  RAM write data, equal to data.
- ram_dataOut  in  32  RAM read data, valid one cycle after the address.
- btn_in  in  N_BTN  raw asynchronous button inputs.
- led_out  out  N_LED  LED register contents.
- irq  out  1  timer interrupt; equals the pending bit.

Behaviour:
- mmio_sel = (addr >= MMIO_BASE), combinational. off = addr - MMIO_BASE.
- MMIO offsets:
  - 0 LED: RW, low N_LED bits.
  - 1 BTN_LEVEL: RO, debounced levels.
  - 2 BTN_EDGE: RO sticky rising-edge flags; cleared by read; write-1-to-clear.
  - 3 TMR_COUNT: RO.
  - 4 TMR_CMP: RW.
  - 5 TMR_CTRL: bit0 enable (RW); bit1 pending (read; W1C); bit2 write-1 clears the count (self-clearing, reads 0).
  - Other offsets read 0; writes to them are ignored.
  - Unused upper bits read 0.
- Read latency is 1 cycle for both targets, matching RAM:
  - sel_q <= mmio_sel, registered.
  - mmio_rd_q <= the MMIO register value, registered.
  - q_dmem = sel_q ? mmio_rd_q : ram_dataOut.
- Any access with wren=0 and off==2 counts as a read. The edge bits sampled into mmio_rd_q are cleared that cycle.
- Buttons:
  - Two-flop synchroniser per bit.
  - Per-button counter: resets to 0 when the synced input equals the debounced level. Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, the level toggles and the counter returns to 0.
  - A 0->1 transition of the debounced level sets the edge bit.
- Simultaneous edge set and clear (read-clear or W1C) on the same bit in the same cycle: set wins.
- Timer:
  - When enable=1, count increments by 1 per cycle and wraps 0xFFFFFFFF -> 0.
  - When enable=1 and count == cmp, pending <= 1 on that cycle. pending stays set until W1C.
  - A W1C of pending in the same cycle as a new match: set wins.
  - Clear-count (bit2) and increment in the same cycle: count <= 0.
- Reset (asserted at any time, including mid-access) forces all of the following to 0: LED, levels, edges, counters, synchronisers, count, cmp, enable, pending, sel_q, mmio_rd_q. So q_dmem=ram_dataOut, led_out=0, irq=0. Deassertion requires no extra cycles.

Decomposition:
- Package mmio_pkg holds:
  - offset constants OFF_LED..OFF_TMR_CTRL;
  - TMR_CTRL bit indices;
  - the default MMIO_BASE.
- One sub-module, btn_debounce (synchroniser, counter and level for one button, parameter DEBOUNCE_CYCLES), generate-instanced N_BTN times.
- Edge flags and all register logic stay in mmio_hub.

Test Plan:
- RAM passthrough: write 0x12345678 to 0x010, then read 0x010 -> ram_wEn=1 on the write; q_dmem=0x12345678 one cycle after the read address; led_out unchanged.
- LED write: write 0xFFFFFFA5 to 0xF00 -> ram_wEn=0; led_out=0xA5 next cycle; read 0xF00 returns 0x000000A5.
- Debounce (DEBOUNCE_CYCLES=4):
  - 2-cycle glitch on btn_in[1] -> level stays 0.
  - Steady high -> BTN_LEVEL reads 0x2 after 2 sync + 4 cycles; BTN_EDGE reads 0x2, then 0x0 on a second read.
  - Edge arriving in the same cycle as the clearing read -> bit remains set.
- Timer: cmp=5, enable=1 -> irq rises the cycle count==5; count wraps from preload 0xFFFFFFFF by clear+run check; writing 0x2 to CTRL drops irq.
- Async reset: assert reset low mid-read while led_out=0xA5 and irq=1 -> led_out=0, irq=0, q_dmem=ram_dataOut immediately, without waiting for a clock edge.
